// File: rtl/i_fetch_pkg.sv
// Shared widths, fetch FSM encodings and PC step for the LEGv8 fetch stage.
package i_fetch_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    localparam logic [WORD-1:0] PC_INCR = 64'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_BUSY    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs; flush empties it in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    // A pop frees the slot in the same cycle, so push at full is legal with pop.
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && full && !do_pop));

endmodule

// File: rtl/i_fetch.sv
// LEGv8 instruction-fetch stage: PC owner, single-outstanding imem requester, prefetch buffer.
module i_fetch
    import i_fetch_pkg::*;
#(
    parameter int              FIFO_DEPTH = 2,
    parameter logic [WORD-1:0] RESET_PC   = 64'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD-1:0]      redirect_pc,
    output logic                 imem_req,
    output logic [WORD-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_LEN-1:0] imem_rdata,
    output logic                 instr_valid,
    output logic [INSTR_LEN-1:0] instruction,
    output logic [WORD-1:0]      cur_pc_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = WORD + INSTR_LEN;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t    state;
    logic [WORD-1:0] pc;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic [FW-1:0]   head;
    logic            ack;
    logic            push;
    logic            pop;
    logic            credit_idle;
    logic            credit_after_ack;

    assign ack  = imem_ack && imem_req;
    assign push = (state == FETCH_BUSY) && ack && !redirect;
    assign pop  = !empty && !stall && !redirect;

    // Credits use this cycle's occupancy; an entry popped now frees a slot only next cycle.
    assign credit_idle      = (count < DEPTH_C);
    assign credit_after_ack = ((count + 1'b1) < DEPTH_C);

    assign instr_valid = !empty;
    assign {cur_pc_out, instruction} = empty ? '0 : head;

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({imem_addr, imem_rdata}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH_IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else if (redirect) begin
            // The flush leaves the FIFO empty, so a credit is always available here.
            pc <= redirect_pc;
            case (state)
                FETCH_IDLE: begin
                    state     <= FETCH_BUSY;
                    imem_req  <= 1'b1;
                    imem_addr <= redirect_pc;
                end
                FETCH_BUSY: begin
                    if (ack) begin
                        imem_addr <= redirect_pc;
                    end else begin
                        state <= FETCH_DISCARD;
                    end
                end
                FETCH_DISCARD: begin
                    if (ack) begin
                        state     <= FETCH_BUSY;
                        imem_addr <= redirect_pc;
                    end
                end
                default: begin
                    state    <= FETCH_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (credit_idle) begin
                        state     <= FETCH_BUSY;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                FETCH_BUSY: begin
                    if (ack) begin
                        pc <= pc + PC_INCR;
                        if (credit_after_ack) begin
                            imem_addr <= pc + PC_INCR;
                        end else begin
                            state    <= FETCH_IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                FETCH_DISCARD: begin
                    if (ack) begin
                        if (credit_idle) begin
                            state     <= FETCH_BUSY;
                            imem_addr <= pc;
                        end else begin
                            state    <= FETCH_IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= FETCH_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_fetch.sv
// Directed bench for i_fetch: memory responder with programmable latency and an in-order pop scoreboard.
module tb_i_fetch;
    import i_fetch_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 stall = 1'b0;
    logic                 redirect = 1'b0;
    logic [WORD-1:0]      redirect_pc = '0;
    logic                 imem_req;
    logic [WORD-1:0]      imem_addr;
    logic                 imem_ack = 1'b0;
    logic [INSTR_LEN-1:0] imem_rdata = '0;
    logic                 instr_valid;
    logic [INSTR_LEN-1:0] instruction;
    logic [WORD-1:0]      cur_pc_out;

    int              n_checks = 0;
    int              n_pass = 0;
    int              latency = 0;
    bit              force_ack = 1'b0;
    bit              abandon = 1'b0;
    bit              mon_en = 1'b0;
    logic [WORD-1:0] exp_pc = '0;

    always #5 clk = ~clk;

    i_fetch #(.FIFO_DEPTH(2), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .cur_pc_out  (cur_pc_out)
    );

    function automatic logic [31:0] img(input logic [63:0] a);
        return {4'hF, a[27:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_addr(input logic [63:0] a, input string tag);
        for (int n = 0; n < 60; n++) begin
            if (imem_req && imem_addr == a) break;
            tick();
        end
        chk(tag, {63'b0, (imem_req && imem_addr == a)}, 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 60; n++) begin
            if (instr_valid) break;
            tick();
        end
        chk(tag, {63'b0, instr_valid}, 64'd1);
    endtask

    task automatic do_reset();
        abandon = 1'b1;
        reset   = 1'b1;
        tick();
        tick();
        exp_pc = 64'h0;
        reset  = 1'b0;
    endtask

    // Memory responder: acks after `latency` wait cycles and checks request stability.
    initial begin
        int              cnt;
        bit              pending;
        logic [63:0]     paddr;
        cnt = 0;
        pending = 1'b0;
        paddr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (abandon || reset) begin
                pending = 1'b0;
                cnt     = 0;
                abandon = 1'b0;
            end
            if (force_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEADBEEF;
                pending    = 1'b0;
                cnt        = 0;
            end else if (imem_req) begin
                if (pending) chk("addr_hold", imem_addr, paddr);
                if (cnt == latency) begin
                    imem_ack   = 1'b1;
                    imem_rdata = img(imem_addr);
                    cnt        = 0;
                    pending    = 1'b0;
                end else begin
                    imem_ack = 1'b0;
                    cnt++;
                    pending  = 1'b1;
                    paddr    = imem_addr;
                end
            end else begin
                if (pending) chk("req_hold", {63'b0, imem_req}, 64'd1);
                imem_ack = 1'b0;
                cnt      = 0;
                pending  = 1'b0;
            end
        end
    end

    // Every popped entry must be the next in-order PC with its matching instruction.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !reset && instr_valid && !stall && !redirect) begin
                $display("pop pc=%h instr=%h", cur_pc_out, instruction);
                chk("pop_pc", cur_pc_out, exp_pc);
                chk("pop_instr", {32'b0, instruction}, {32'b0, img(exp_pc)});
                exp_pc = exp_pc + 64'd4;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_req", {63'b0, imem_req}, 64'd0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", {63'b0, instr_valid}, 64'd0);
        chk("rst_instr", {32'b0, instruction}, 64'd0);
        chk("rst_pc", cur_pc_out, 64'h0);

        // Zero-wait streaming: first valid two cycles after release
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();
        chk("lat_req", {63'b0, imem_req}, 64'd1);
        chk("lat_addr0", imem_addr, 64'h0);
        chk("lat_valid0", {63'b0, instr_valid}, 64'd0);
        tick();
        chk("lat_valid1", {63'b0, instr_valid}, 64'd1);
        chk("lat_pc0", cur_pc_out, 64'h0);
        chk("lat_addr4", imem_addr, 64'h4);
        for (int i = 0; i < 12; i++) tick();
        chk("stream_progress", {63'b0, (exp_pc >= 64'h10)}, 64'd1);

        // Stall fills the FIFO and stops requesting
        stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_count", {62'b0, dut.count}, 64'd2);
        chk("stall_req", {63'b0, imem_req}, 64'd0);
        chk("stall_valid", {63'b0, instr_valid}, 64'd1);
        chk("stall_head", cur_pc_out, exp_pc);
        stall = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Redirect in the 2nd cycle of a 3-wait request to 0x8
        do_reset();
        latency = 3;
        wait_addr(64'h8, "t3_wait8");
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        exp_pc      = 64'h100;
        tick();
        redirect = 1'b0;
        chk("disc_req", {63'b0, imem_req}, 64'd1);
        chk("disc_addr", imem_addr, 64'h8);
        wait_addr(64'h100, "t3_wait100");
        wait_valid("t3_valid");
        chk("t3_pc", cur_pc_out, 64'h100);

        // Redirect coinciding with a zero-wait ack
        latency = 0;
        do_reset();
        wait_addr(64'h8, "t4_wait8");
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        exp_pc      = 64'h200;
        tick();
        redirect = 1'b0;
        chk("t4_req", {63'b0, imem_req}, 64'd1);
        chk("t4_addr", imem_addr, 64'h200);
        wait_valid("t4_valid");
        chk("t4_pc", cur_pc_out, 64'h200);

        // Redirect while stalled with two buffered entries
        stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_count", {62'b0, dut.count}, 64'd2);
        redirect    = 1'b1;
        redirect_pc = 64'h300;
        exp_pc      = 64'h300;
        tick();
        redirect = 1'b0;
        chk("t5_flush", {63'b0, instr_valid}, 64'd0);
        chk("t5_addr", imem_addr, 64'h300);
        stall = 1'b0;
        wait_valid("t5_valid");
        chk("t5_pc", cur_pc_out, 64'h300);

        // Asynchronous reset mid-request at 0x44 with 0x40 buffered
        do_reset();
        latency     = 3;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h40;
        exp_pc      = 64'h40;
        tick();
        redirect = 1'b0;
        wait_addr(64'h44, "t6_wait44");
        tick();
        chk("t6_pre_pc", cur_pc_out, 64'h40);
        #1;
        abandon = 1'b1;
        reset   = 1'b1;
        #1;
        chk("t6_req", {63'b0, imem_req}, 64'd0);
        chk("t6_addr", imem_addr, 64'h0);
        chk("t6_valid", {63'b0, instr_valid}, 64'd0);
        chk("t6_pc", cur_pc_out, 64'h0);
        chk("t6_instr", {32'b0, instruction}, 64'd0);
        tick();
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        stall     = 1'b0;
        exp_pc    = 64'h0;
        reset     = 1'b0;
        wait_valid("t6_valid_after");
        chk("t6_restart_pc", cur_pc_out, 64'h0);
        chk("t6_restart_instr", {32'b0, instruction}, {32'b0, img(64'h0)});
        for (int i = 0; i < 6; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
